// File: rtl/button_press_pkg.sv
// Shared definitions for the push-button event decoder: FSM state encoding
// and the default prescaler length.
package button_press_pkg;

   // Clock cycles per millisecond tick at the default 100 MHz system clock.
   localparam int TICK_MAX_DEFAULT = 100_000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_e;

endpackage

// File: rtl/button_press_ms_tick.sv
// Millisecond prescaler: free-running modulo-TICK_MAX counter with a
// synchronous clear. tick is high while the count sits on its last value.
module button_press_ms_tick
   import button_press_pkg::*;
#(
   parameter int TICK_MAX = TICK_MAX_DEFAULT
) (
   input  logic ck,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int PW = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
   localparam logic [PW-1:0] CNT_LAST = PW'(TICK_MAX - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   // Next count: wrap at the terminal value, clear has priority.
   always_comb begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (clr) begin
         cnt_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge ck) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/button_press.sv
// Push-button event decoder: turns the debounced button level into
// single-cycle short-press, long-press and auto-repeat pulses plus a held
// level. All outputs are registered.
module button_press
   import button_press_pkg::*;
#(
   parameter int TICK_MAX  = TICK_MAX_DEFAULT,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic ck,
   input  logic reset,
   input  logic button_deb,
   output logic press,
   output logic long_press,
   output logic repeat_pulse,
   output logic held
);

   localparam int MS_W  = (LONG_MS > 2) ? $clog2(LONG_MS) : 1;
   localparam int REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;
   localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(LONG_MS - 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_MS - 1);

   state_e           state_q, state_d;
   logic [MS_W-1:0]  ms_q, ms_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic             press_q, press_d;
   logic             long_q, long_d;
   logic             rpt_q, rpt_d;
   logic             held_q, held_d;
   logic             presc_clr;
   logic             tick;

   // The prescaler restarts on every new press so timing never carries
   // over from an earlier press; it is not cleared on entry to LONG.
   button_press_ms_tick #(
      .TICK_MAX(TICK_MAX)
   ) u_ms_tick (
      .ck   (ck),
      .reset(reset),
      .clr  (presc_clr),
      .tick (tick)
   );

   // Next-state, counter and pulse decode.
   always_comb begin
      state_d   = state_q;
      ms_d      = ms_q;
      rep_d     = rep_q;
      press_d   = 1'b0;
      long_d    = 1'b0;
      rpt_d     = 1'b0;
      presc_clr = 1'b0;
      case (state_q)
         IDLE: begin
            ms_d  = '0;
            rep_d = '0;
            if (button_deb) begin
               state_d   = PRESSED;
               presc_clr = 1'b1;
            end
         end
         PRESSED: begin
            // Release is checked first so it wins over a coincident threshold.
            if (!button_deb) begin
               state_d = IDLE;
               press_d = 1'b1;
            end else if (tick) begin
               if (ms_q == MS_LAST) begin
                  state_d = LONG;
                  long_d  = 1'b1;
                  rep_d   = '0;
               end else begin
                  ms_d = ms_q + 1'b1;
               end
            end
         end
         LONG: begin
            // Release suppresses any repeat falling due in the same cycle.
            if (!button_deb) begin
               state_d = IDLE;
            end else if (tick) begin
               if (rep_q == REP_LAST) begin
                  rep_d = '0;
                  rpt_d = 1'b1;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      held_d = (state_d != IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge ck) begin
      if (reset) begin
         state_q <= IDLE;
         ms_q    <= '0;
         rep_q   <= '0;
         press_q <= 1'b0;
         long_q  <= 1'b0;
         rpt_q   <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ms_q    <= ms_d;
         rep_q   <= rep_d;
         press_q <= press_d;
         long_q  <= long_d;
         rpt_q   <= rpt_d;
         held_q  <= held_d;
      end
   end

   assign press        = press_q;
   assign long_press   = long_q;
   assign repeat_pulse = rpt_q;
   assign held         = held_q;

endmodule
